// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipelined RV32I core.
//   * load-use hazard (load in EX, dependent instruction in ID): one bubble
//   * taken branch resolved in MEM: flush IF/ID, ID/EX and EX/MEM
//   * data-memory access waiting on dmem_ready: freeze the front of the pipe
//     and inject bubbles into MEM/WB until the access completes
//   * a dmem access stuck longer than MEM_TIMEOUT cycles in WAIT raises a
//     sticky mem_timeout and parks the sequencer in HALT until RESET
// ALU-to-ALU hazards are covered by the forwarding unit, not here.
//
// Priority per cycle: HALT > dmem wait > taken branch > load-use > normal.
// While RESET is high every enable and every flush is forced to 1 so the pipe
// fills with bubbles.
//
// Optional feature (compile-time macro HAZARD_PERF_CNT_EN):
//   defined     -> stall_cnt / flush_cnt / wait_cnt performance counters
//   not defined -> counters absent, the three ports are tied to 0
//
// Parameters
//   MEM_TIMEOUT  cycles allowed in WAIT on one access before HALT (>=1)
//   CNT_SIZE     width of the performance counters
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   rs1_id, rs2_id      source register fields of the ID instruction
//   rs1_used_id/rs2_used_id  ID instruction actually reads rs1/rs2
//   mem_read_ex, rd_ex  EX instruction is a load / its destination
//   branch_taken_mem    branch in MEM is taken
//   dmem_req_mem        MEM instruction accesses data memory
//   dmem_ready          data memory completes the access this cycle
//   pc_en, if_id_en, id_ex_en, ex_mem_en      register load enables
//   flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  bubble inserts
//   state               00 RUN, 01 WAIT, 11 HALT
//   mem_timeout         sticky timeout flag
//   stall_cnt, flush_cnt, wait_cnt  performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_SIZE    = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [4:0]          rs1_id,
    input  logic [4:0]          rs2_id,
    input  logic                rs1_used_id,
    input  logic                rs2_used_id,
    input  logic                mem_read_ex,
    input  logic [4:0]          rd_ex,
    input  logic                branch_taken_mem,
    input  logic                dmem_req_mem,
    input  logic                dmem_ready,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                id_ex_en,
    output logic                ex_mem_en,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic                flush_ex_mem,
    output logic                flush_mem_wb,
    output logic [1:0]          state,
    output logic                mem_timeout,
    output logic [CNT_SIZE-1:0] stall_cnt,
    output logic [CNT_SIZE-1:0] flush_cnt,
    output logic [CNT_SIZE-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HALT = 2'b11
    } state_t;

    // Wide enough to hold the value MEM_TIMEOUT itself.
    localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WCNT_ONE    = WCW'(1);

    state_t         state_reg, state_next;
    logic [WCW-1:0] wcnt_reg, wcnt_next;
    logic           timeout_reg, timeout_next;

    // Action selected for this cycle (mutually exclusive, priority resolved
    // in the FSM below). freeze_act covers only RUN/WAIT, not HALT, so it is
    // exactly the set of cycles the wait counter should count.
    logic load_use;
    logic freeze_act;
    logic halt_act;
    logic branch_act;
    logic stall_act;

    // rd_ex==0 never creates a dependency: x0 is hardwired to zero.
    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rs1_used_id && (rs1_id == rd_ex)) ||
                       (rs2_used_id && (rs2_id == rd_ex)));

    // ------------------------------------------------------------------
    // Next-state and action selection
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        wcnt_next    = wcnt_reg;
        timeout_next = timeout_reg;
        freeze_act   = 1'b0;
        halt_act     = 1'b0;
        branch_act   = 1'b0;
        stall_act    = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (dmem_req_mem && !dmem_ready) begin
                    // The cycle that discovers the wait is itself the first
                    // wait cycle.
                    freeze_act = 1'b1;
                    wcnt_next  = WCNT_ONE;
                    state_next = ST_WAIT;
                end else begin
                    // A taken branch makes the stalled ID instruction
                    // wrong-path, so the branch suppresses the stall.
                    branch_act = branch_taken_mem;
                    stall_act  = !branch_taken_mem && load_use;
                end
            end

            ST_WAIT: begin
                if (dmem_ready) begin
                    // Access completes: behave as RUN for this cycle. The
                    // dmem request is the one that just finished, so it is
                    // not re-examined.
                    wcnt_next  = '0;
                    state_next = ST_RUN;
                    branch_act = branch_taken_mem;
                    stall_act  = !branch_taken_mem && load_use;
                end else begin
                    freeze_act = 1'b1;
                    if (wcnt_reg == TIMEOUT_VAL) begin
                        timeout_next = 1'b1;
                        state_next   = ST_HALT;
                    end else begin
                        wcnt_next = wcnt_reg + WCNT_ONE;
                    end
                end
            end

            ST_HALT: begin
                halt_act = 1'b1;
            end

            default: begin
                // Unused encoding 2'b10: recover to RUN.
                state_next = ST_RUN;
                wcnt_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;

        if (RESET) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (halt_act || freeze_act) begin
            // Hold everything up to EX/MEM; MEM/WB receives bubbles so the
            // waiting access is not written back more than once.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            flush_mem_wb = 1'b1;
        end else if (branch_act) begin
            // pc_en stays 1 so the branch target is loaded.
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (stall_act) begin
            // Hold PC and IF/ID, let the load advance, bubble into EX.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            flush_id_ex = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ST_RUN;
            wcnt_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wcnt_reg    <= wcnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign state       = state_reg;
    assign mem_timeout = timeout_reg;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    // Index 0: load-use stall cycles, 1: taken-branch flushes, 2: wait cycles.
    logic [2:0]          perf_inc;
    logic [CNT_SIZE-1:0] perf_cnt_reg [3];

    assign perf_inc = {freeze_act, branch_act, stall_act};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf_cnt
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (perf_inc[gi]) begin
                    // Wraps modulo 2^CNT_SIZE.
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = perf_cnt_reg[0];
    assign flush_cnt = perf_cnt_reg[1];
    assign wait_cnt  = perf_cnt_reg[2];
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed testbench for hazard_ctrl. Inputs change 1 time unit after the
// rising edge; the combinational outputs are checked before the next edge.
// Control outputs are compared as one packed byte:
//   {pc_en, if_id_en, id_ex_en, ex_mem_en,
//    flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}
// Counter expectations apply when HAZARD_PERF_CNT_EN is defined; otherwise
// the counter ports must read 0.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [7:0] C_NORMAL = 8'b1111_0000;
    localparam logic [7:0] C_STALL  = 8'b0011_0100;
    localparam logic [7:0] C_BRANCH = 8'b1111_1110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0001;
    localparam logic [7:0] C_RESET  = 8'b1111_1111;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        rs1_used_id, rs2_used_id, mem_read_ex;
    logic        branch_taken_mem, dmem_req_mem, dmem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
    logic [7:0]  ctrl;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(
        .MEM_TIMEOUT (16),
        .CNT_SIZE    (32)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .rs1_id           (rs1_id),
        .rs2_id           (rs2_id),
        .rs1_used_id      (rs1_used_id),
        .rs2_used_id      (rs2_used_id),
        .mem_read_ex      (mem_read_ex),
        .rd_ex            (rd_ex),
        .branch_taken_mem (branch_taken_mem),
        .dmem_req_mem     (dmem_req_mem),
        .dmem_ready       (dmem_ready),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_ex_en         (id_ex_en),
        .ex_mem_en        (ex_mem_en),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .flush_ex_mem     (flush_ex_mem),
        .flush_mem_wb     (flush_mem_wb),
        .state            (state),
        .mem_timeout      (mem_timeout),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt),
        .wait_cnt         (wait_cnt)
    );

    assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                   flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        rs1_id           = 5'd0;
        rs2_id           = 5'd0;
        rs1_used_id      = 1'b0;
        rs2_used_id      = 1'b0;
        mem_read_ex      = 1'b0;
        rd_ex            = 5'd0;
        branch_taken_mem = 1'b0;
        dmem_req_mem     = 1'b0;
        dmem_ready       = 1'b0;
    endtask

    // One ID/EX dependency vector.
    task automatic set_dep(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                           input logic u1, input logic [4:0] r2, input logic u2,
                           input logic br);
        idle();
        mem_read_ex      = mr;
        rd_ex            = rd;
        rs1_id           = r1;
        rs1_used_id      = u1;
        rs2_id           = r2;
        rs2_used_id      = u2;
        branch_taken_mem = br;
    endtask

    task automatic check_cnt(input string tag, input int s, input int f, input int w);
        check({tag, ".stall_cnt"}, 64'(stall_cnt), PERF ? 64'(s) : 64'd0);
        check({tag, ".flush_cnt"}, 64'(flush_cnt), PERF ? 64'(f) : 64'd0);
        check({tag, ".wait_cnt"},  64'(wait_cnt),  PERF ? 64'(w) : 64'd0);
    endtask

    initial begin
        // ---------------- reset ----------------
        RESET = 1'b1;
        idle();
        tick();
        tick();
        check("rst.ctrl", 64'(ctrl), 64'(C_RESET));
        check("rst.state", 64'(state), 64'd0);
        check("rst.timeout", 64'(mem_timeout), 64'd0);
        check_cnt("rst", 0, 0, 0);
        RESET = 1'b0;
        #1;
        check("run.normal", 64'(ctrl), 64'(C_NORMAL));
        tick();

        // ---------------- load-use / branch vectors ----------------
        // lw x5 in EX, add x6,x5,x1 in ID
        set_dep(1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0); #1;
        check("lu.rs1", 64'(ctrl), 64'(C_STALL));
        tick();
        // load moved to MEM, EX holds the bubble
        set_dep(1'b0, 5'd0, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0); #1;
        check("lu.after", 64'(ctrl), 64'(C_NORMAL));
        tick();
        // lw x0: never a hazard
        set_dep(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); #1;
        check("lu.x0", 64'(ctrl), 64'(C_NORMAL));
        tick();
        // rs2 matches but is not used
        set_dep(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0); #1;
        check("lu.rs2_unused", 64'(ctrl), 64'(C_NORMAL));
        tick();
        // rs2 matches and is used
        set_dep(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0); #1;
        check("lu.rs2", 64'(ctrl), 64'(C_STALL));
        tick();
        // not a load: no stall even with a match
        set_dep(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0); #1;
        check("lu.not_load", 64'(ctrl), 64'(C_NORMAL));
        tick();
        // taken branch beats load-use
        set_dep(1'b1, 5'd9, 5'd9, 1'b1, 5'd2, 1'b1, 1'b1); #1;
        check("br.over_lu", 64'(ctrl), 64'(C_BRANCH));
        tick();
        // plain taken branch
        set_dep(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1); #1;
        check("br.plain", 64'(ctrl), 64'(C_BRANCH));
        tick();
        // access ready in same cycle: no stall
        idle();
        dmem_req_mem = 1'b1;
        dmem_ready   = 1'b1; #1;
        check("dm.ready_now", 64'(ctrl), 64'(C_NORMAL));
        tick();
        check_cnt("mid", 2, 2, 0);

        // ---------------- dmem wait, 3 cycles ----------------
        idle();
        dmem_req_mem = 1'b1; #1;
        check("dm.w0.ctrl", 64'(ctrl), 64'(C_FREEZE));
        check("dm.w0.state", 64'(state), 64'd0);
        tick();
        for (int i = 1; i < 3; i++) begin
            check($sformatf("dm.w%0d.state", i), 64'(state), 64'd1);
            check($sformatf("dm.w%0d.ctrl", i), 64'(ctrl), 64'(C_FREEZE));
            tick();
        end
        // completes together with a taken branch: evaluated as RUN
        dmem_ready       = 1'b1;
        branch_taken_mem = 1'b1; #1;
        check("dm.done.ctrl", 64'(ctrl), 64'(C_BRANCH));
        check("dm.done.state", 64'(state), 64'd1);
        tick();
        idle(); #1;
        check("dm.run.state", 64'(state), 64'd0);
        check("dm.run.ctrl", 64'(ctrl), 64'(C_NORMAL));
        check_cnt("dm", 2, 3, 3);
        tick();

        // ---------------- reset in the middle of WAIT ----------------
        idle();
        dmem_req_mem = 1'b1;
        tick();
        check("rw.state", 64'(state), 64'd1);
        RESET = 1'b1; #1;
        check("rw.ctrl", 64'(ctrl), 64'(C_RESET));
        tick();
        RESET = 1'b0;
        idle(); #1;
        check("rw.after.state", 64'(state), 64'd0);
        check("rw.after.ctrl", 64'(ctrl), 64'(C_NORMAL));
        check_cnt("rw", 0, 0, 0);
        tick();

        // ---------------- timeout ----------------
        idle();
        dmem_req_mem = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("to.w%0d.state", i), 64'(state), 64'd1);
            check($sformatf("to.w%0d.timeout", i), 64'(mem_timeout), 64'd0);
            tick();
        end
        check("to.halt.state", 64'(state), 64'd3);
        check("to.halt.timeout", 64'(mem_timeout), 64'd1);
        check("to.halt.ctrl", 64'(ctrl), 64'(C_FREEZE));
        // HALT ignores ready, branches and hazards
        dmem_ready       = 1'b1;
        branch_taken_mem = 1'b1;
        tick();
        set_dep(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0); #1;
        check("to.hold.state", 64'(state), 64'd3);
        check("to.hold.ctrl", 64'(ctrl), 64'(C_FREEZE));
        tick();
        check_cnt("to", 0, 0, 17);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        idle(); #1;
        check("to.clr.state", 64'(state), 64'd0);
        check("to.clr.timeout", 64'(mem_timeout), 64'd0);
        check_cnt("to.clr", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
